// File: rtl/csa_stream_accum.sv
// csa_stream_accum: frame accumulator for a valid/ready stream of unsigned
// operands. Beats are summed in carry-save form (S, C) so that the per-beat
// path is a single full-adder layer. The one carry-propagate add is done
// once per frame in the RES state. The frame sum is then held in OUT until
// the consumer takes it.
module csa_stream_accum #(
   parameter int IN_W  = 21,
   parameter int ACC_W = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      ACC = 2'd0,
      RES = 2'd1,
      OUT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // Bitwise majority: the carry vector of a full-adder layer.
   function automatic logic [ACC_W-1:0] maj3(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b,
                                             input logic [ACC_W-1:0] c);
      maj3 = (a & b) | (a & c) | (b & c);
   endfunction

   state_t             state_r;
   logic [ACC_W-1:0]   s_r;
   logic [ACC_W-1:0]   c_r;
   logic [CNT_W-1:0]   cnt_r;
   logic               drop_r;
   logic               in_ready_r;
   logic               out_valid_r;
   logic [ACC_W-1:0]   out_data_r;
   logic [CNT_W-1:0]   out_count_r;
   logic               out_ovf_r;

   logic [ACC_W-1:0]   x_s;
   logic [ACC_W-1:0]   maj_s;
   logic [ACC_W:0]     sum_s;
   logic               accept_s;
   logic               hand_s;

   // Per-beat carry-save terms and the once-per-frame resolving add.
   always_comb begin
      x_s      = {{(ACC_W-IN_W){1'b0}}, in_data};
      maj_s    = maj3(s_r, c_r, x_s);
      sum_s    = {1'b0, s_r} + {1'b0, c_r};
      accept_s = 1'b0;
      hand_s   = 1'b0;
      if (state_r == ACC) begin
         accept_s = in_valid;
      end else if (state_r == OUT) begin
         hand_s = out_ready;
      end else begin
         accept_s = 1'b0;
         hand_s   = 1'b0;
      end
   end

   // Frame FSM, carry-save accumulator and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ACC;
         s_r         <= {ACC_W{1'b0}};
         c_r         <= {ACC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         drop_r      <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_data_r  <= {ACC_W{1'b0}};
         out_count_r <= {CNT_W{1'b0}};
         out_ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            ACC: begin
               if (accept_s) begin
                  s_r <= s_r ^ c_r ^ x_s;
                  c_r <= {maj_s[ACC_W-2:0], 1'b0};
                  // The majority MSB would shift out of C: remember it.
                  if (maj_s[ACC_W-1]) begin
                     drop_r <= 1'b1;
                  end
                  if (cnt_r != CNT_MAX) begin
                     cnt_r <= cnt_r + CNT_ONE;
                  end
                  if (in_last) begin
                     state_r    <= RES;
                     in_ready_r <= 1'b0;
                  end
               end
            end
            RES: begin
               out_data_r  <= sum_s[ACC_W-1:0];
               out_ovf_r   <= drop_r | sum_s[ACC_W];
               out_count_r <= cnt_r;
               out_valid_r <= 1'b1;
               state_r     <= OUT;
            end
            OUT: begin
               if (hand_s) begin
                  s_r         <= {ACC_W{1'b0}};
                  c_r         <= {ACC_W{1'b0}};
                  cnt_r       <= {CNT_W{1'b0}};
                  drop_r      <= 1'b0;
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ACC;
               end
            end
            default: begin
               state_r     <= ACC;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_count = out_count_r;
   assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_csa_stream_accum.sv
// tb_csa_stream_accum: directed bench for csa_stream_accum. Two instances
// (ACC_W=32 and ACC_W=22) receive identical stimulus. A reference model
// keeps the true frame sum and pushes expected results to a queue on each
// last beat. The queue is popped when the DUTs present a result.
module tb_csa_stream_accum;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_last, out_ready;
   logic [20:0] in_data;

   logic        in_ready_a, out_valid_a, out_ovf_a;
   logic [31:0] out_data_a;
   logic [7:0]  out_count_a;
   logic        in_ready_b, out_valid_b, out_ovf_b;
   logic [21:0] out_data_b;
   logic [7:0]  out_count_b;

   typedef struct {
      logic [31:0] d32;
      logic        ovf32;
      logic [21:0] d22;
      logic        ovf22;
      logic [7:0]  cnt;
   } exp_t;

   exp_t        sb[$];
   logic [63:0] mdl_sum;
   int          mdl_cnt;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   csa_stream_accum #(.IN_W(21), .ACC_W(32), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
      .out_count(out_count_a), .out_ovf(out_ovf_a)
   );

   csa_stream_accum #(.IN_W(21), .ACC_W(22), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
      .out_count(out_count_b), .out_ovf(out_ovf_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      idle(n);
      rst_n   = 1'b1;
      mdl_sum = 64'd0;
      mdl_cnt = 0;
      sb.delete();
   endtask

   // Drive one beat; it is accepted on the next edge while in_ready is high.
   task automatic send_beat(input logic [20:0] d, input logic last);
      int   n;
      exp_t e;
      n        = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready_a !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_before_beat", {63'd0, in_ready_a}, 64'd1);
      @(posedge clk);
      mdl_sum = mdl_sum + {43'd0, d};
      if (mdl_cnt < 255) mdl_cnt++;
      if (last) begin
         e.d32   = mdl_sum[31:0];
         e.ovf32 = (mdl_sum >= 64'h1_0000_0000);
         e.d22   = mdl_sum[21:0];
         e.ovf22 = (mdl_sum >= 64'h40_0000);
         e.cnt   = 8'(mdl_cnt);
         sb.push_back(e);
         mdl_sum = 64'd0;
         mdl_cnt = 0;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called right after the last beat's accepting edge. Waits for the result,
   // holds it for 'hold' cycles (optionally with junk input), then takes it.
   task automatic collect(input int hold, input logic junk);
      int   n;
      exp_t e;
      n = 0;
      chk("res_out_valid_low", {63'd0, out_valid_a}, 64'd0);
      chk("res_in_ready_low", {63'd0, in_ready_a}, 64'd0);
      while (out_valid_a !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk("latency_edges", 64'(n), 64'd1);
      chk("valid_lockstep", {63'd0, out_valid_b}, 64'd1);
      chk("sb_nonempty", 64'(sb.size()), 64'd1);
      if (sb.size() > 0) e = sb.pop_front();
      chk("out_data32", {32'd0, out_data_a}, {32'd0, e.d32});
      chk("out_count32", {56'd0, out_count_a}, {56'd0, e.cnt});
      chk("out_ovf32", {63'd0, out_ovf_a}, {63'd0, e.ovf32});
      chk("out_data22", {42'd0, out_data_b}, {42'd0, e.d22});
      chk("out_count22", {56'd0, out_count_b}, {56'd0, e.cnt});
      chk("out_ovf22", {63'd0, out_ovf_b}, {63'd0, e.ovf22});
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         if (junk) begin
            in_valid = 1'b1;
            in_data  = 21'($urandom);
            in_last  = 1'b1;
         end
         tick();
         chk("hold_valid", {63'd0, out_valid_a}, 64'd1);
         chk("hold_in_ready", {63'd0, in_ready_a}, 64'd0);
         chk("hold_data32", {32'd0, out_data_a}, {32'd0, e.d32});
         chk("hold_count32", {56'd0, out_count_a}, {56'd0, e.cnt});
         chk("hold_ovf22", {63'd0, out_ovf_b}, {63'd0, e.ovf22});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      chk("post_hs_valid", {63'd0, out_valid_a}, 64'd0);
      chk("post_hs_in_ready", {63'd0, in_ready_a}, 64'd1);
      chk("post_hs_data_kept", {32'd0, out_data_a}, {32'd0, e.d32});
   endtask

   initial begin
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = 21'd0;
      out_ready = 1'b0;
      mdl_sum   = 64'd0;
      mdl_cnt   = 0;

      // Reset for two cycles.
      do_reset(2);
      chk("rst_in_ready", {63'd0, in_ready_a}, 64'd1);
      chk("rst_out_valid", {63'd0, out_valid_a}, 64'd0);
      chk("rst_out_data", {32'd0, out_data_a}, 64'd0);
      chk("rst_out_count", {56'd0, out_count_a}, 64'd0);
      chk("rst_out_ovf", {63'd0, out_ovf_a}, 64'd0);
      chk("rst_in_ready22", {63'd0, in_ready_b}, 64'd1);

      // Basic frame with idle gaps: 5, 7, 9 -> 21.
      send_beat(21'd5, 1'b0);
      idle(2);
      send_beat(21'd7, 1'b0);
      idle(3);
      send_beat(21'd9, 1'b1);
      collect(0, 1'b0);
      chk("basic_sum_const", {32'd0, out_data_a}, 64'd21);

      // Single-beat frame at the operand maximum.
      send_beat(21'h1FFFFF, 1'b1);
      collect(0, 1'b0);
      chk("single_const", {32'd0, out_data_a}, 64'h1FFFFF);

      // Backpressure for 4 cycles with junk input, then next frame of 3.
      send_beat(21'd100, 1'b0);
      send_beat(21'd200, 1'b1);
      collect(4, 1'b1);
      send_beat(21'd3, 1'b1);
      collect(0, 1'b0);
      chk("after_bp_const", {32'd0, out_data_a}, 64'd3);

      // Overflow on the 22-bit instance: 0x1FFFFF x3.
      send_beat(21'h1FFFFF, 1'b0);
      send_beat(21'h1FFFFF, 1'b0);
      send_beat(21'h1FFFFF, 1'b1);
      collect(1, 1'b0);
      chk("ovf22_data_const", {42'd0, out_data_b}, 64'h1FFFFD);
      chk("ovf22_flag_const", {63'd0, out_ovf_b}, 64'd1);

      // Reset in the middle of a frame discards it.
      send_beat(21'd10, 1'b0);
      send_beat(21'd20, 1'b0);
      do_reset(1);
      chk("midrst_out_data", {32'd0, out_data_a}, 64'd0);
      chk("midrst_in_ready", {63'd0, in_ready_a}, 64'd1);
      send_beat(21'd4, 1'b1);
      collect(0, 1'b0);
      chk("midrst_const", {32'd0, out_data_a}, 64'd4);

      // Random frame with out_ready held high throughout (ignored in ACC).
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) send_beat(21'($urandom), 1'b0);
      send_beat(21'($urandom), 1'b1);
      collect(2, 1'b0);

      // Long frame: beat counter saturates, sum does not.
      for (int i = 0; i < 299; i++) send_beat(21'h1FFFFF, 1'b0);
      send_beat(21'h1FFFFF, 1'b1);
      collect(0, 1'b0);
      chk("sat_count_const", {56'd0, out_count_a}, 64'd255);

      // Reset while a result is held in OUT.
      send_beat(21'd77, 1'b1);
      tick();
      tick();
      chk("pre_rst_out_valid", {63'd0, out_valid_a}, 64'd1);
      do_reset(1);
      chk("out_rst_out_valid", {63'd0, out_valid_a}, 64'd0);
      chk("out_rst_out_count", {56'd0, out_count_a}, 64'd0);
      chk("out_rst_in_ready", {63'd0, in_ready_a}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
